// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game datapath:
//   - game_state_e   : stateGame encoding produced by gameFSM
//   - motion_state_e : per-frame update sequencer states of sprite_motion_ctrl
//   - SVGA active-area constants
//   - step_from_speed: speed index -> pixels per frame
// -----------------------------------------------------------------------------
package game_pkg;

  // stateGame encoding; gameFSM drives exactly these values.
  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_RUN   = 3'd1,
    GS_PAUSE = 3'd2,
    GS_OVER  = 3'd3
  } game_state_e;

  // Per-frame update sequence: wait for tick, sample inputs, commit.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CLAMP  = 2'd2
  } motion_state_e;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_V_ACTIVE = 600;

  // Signed width used for candidate coordinates: wide enough that
  // 0 - step is negative and 1023 + step does not wrap.
  localparam int COORD_CALC_W = 12;

  // Step size in pixels per frame: 1, 2, 4 or 8.
  function automatic logic [3:0] step_from_speed(input logic [1:0] spd);
    return 4'd1 << spd;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// -----------------------------------------------------------------------------
// axis_step
// Purely combinational one-axis motion step: applies +step / -step / 0 to the
// current coordinate according to two opposing buttons, then clamps the
// result into [0, limit_i].
//   coord_i : current coordinate (W bits, unsigned)
//   step_i  : step size in pixels (1..8)
//   dec_i   : button moving towards 0 (left / up)
//   inc_i   : button moving towards limit (right / down)
//   limit_i : largest legal coordinate
//   next_o  : clamped next coordinate
// -----------------------------------------------------------------------------
module axis_step
  import game_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] coord_i,
  input  logic [3:0]   step_i,
  input  logic         dec_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] next_o
);

  logic signed [COORD_CALC_W-1:0] coord_s;
  logic signed [COORD_CALC_W-1:0] step_s;
  logic signed [COORD_CALC_W-1:0] delta_s;
  logic signed [COORD_CALC_W-1:0] limit_s;
  logic signed [COORD_CALC_W-1:0] cand_s;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path (here unconditionally first), otherwise a latch is inferred.
    coord_s = $signed({{(COORD_CALC_W-W){1'b0}}, coord_i});
    limit_s = $signed({{(COORD_CALC_W-W){1'b0}}, limit_i});
    step_s  = $signed({{(COORD_CALC_W-4){1'b0}}, step_i});
    delta_s = '0;

    // Both or neither button pressed cancel out to no motion.
    if (inc_i && !dec_i) begin
      delta_s = step_s;
    end else if (dec_i && !inc_i) begin
      delta_s = -step_s;
    end

    cand_s = coord_s + delta_s;

    if (cand_s[COORD_CALC_W-1]) begin
      next_o = '0;                      // underflow past the left/top edge
    end else if (cand_s > limit_s) begin
      next_o = limit_i;                 // overflow past the right/bottom edge
    end else begin
      next_o = cand_s[W-1:0];
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Per-frame player sprite position controller feeding printRGB.
//   clk         : system clock
//   reset       : asynchronous, active-low reset
//   frame_tick  : one-cycle pulse at the start of vertical blanking
//   stateGame   : game state from gameFSM (game_state_e encoding)
//   up/down/left/right : debounced direction button levels
//   setSpeed    : debounced speed button level; each press advances speed
//   pos_x/pos_y : sprite top-left corner, committed once per frame
//   speed       : speed index, step = 1 << speed
//   moving      : last commit changed the position
//   update_done : one-cycle pulse on each commit (two cycles after frame_tick)
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
  import game_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20,
  parameter int X_INIT   = 390,
  parameter int Y_INIT   = 290
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [2:0]  stateGame,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        setSpeed,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [1:0]  speed,
  output logic        moving,
  output logic        update_done
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] X_HOME = 11'(X_INIT);
  localparam logic [9:0]  Y_HOME = 10'(Y_INIT);

  motion_state_e state_q, state_d;
  game_state_e   game_q, game_d;
  logic          set_prev_q, set_prev_d;
  logic [1:0]    speed_q, speed_d;
  logic [3:0]    step_q, step_d;
  logic [10:0]   next_x_q, next_x_d;
  logic [9:0]    next_y_q, next_y_d;
  logic [10:0]   pos_x_q, pos_x_d;
  logic [9:0]    pos_y_q, pos_y_d;
  logic          moving_q, moving_d;
  logic          update_done_q, update_done_d;

  logic          set_edge;
  logic [10:0]   step_x;
  logic [9:0]    step_y;
  logic [10:0]   commit_x;
  logic [9:0]    commit_y;

  // Candidate positions from the live buttons and the step captured at tick
  // acceptance; latched in S_SAMPLE.
  axis_step #(.W(11)) u_axis_x (
    .coord_i (pos_x_q),
    .step_i  (step_q),
    .dec_i   (left),
    .inc_i   (right),
    .limit_i (X_MAX),
    .next_o  (step_x)
  );

  axis_step #(.W(10)) u_axis_y (
    .coord_i (pos_y_q),
    .step_i  (step_q),
    .dec_i   (up),
    .inc_i   (down),
    .limit_i (Y_MAX),
    .next_o  (step_y)
  );

  assign set_edge = setSpeed & ~set_prev_q;

  always_comb begin
    state_d       = state_q;
    game_d        = game_q;
    set_prev_d    = setSpeed;
    speed_d       = set_edge ? speed_q + 2'd1 : speed_q;
    step_d        = step_q;
    next_x_d      = next_x_q;
    next_y_d      = next_y_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    moving_d      = moving_q;
    update_done_d = 1'b0;
    commit_x      = pos_x_q;
    commit_y      = pos_y_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          // Step is taken from speed_q before a same-cycle setSpeed edge
          // lands, so a coincident press only affects the following frame.
          step_d  = step_from_speed(speed_q);
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        game_d   = game_state_e'(stateGame);
        next_x_d = step_x;
        next_y_d = step_y;
        state_d  = S_CLAMP;
      end

      S_CLAMP: begin
        case (game_q)
          GS_RUN: begin
            commit_x = next_x_q;
            commit_y = next_y_q;
          end
          GS_IDLE: begin
            commit_x = X_HOME;
            commit_y = Y_HOME;
          end
          default: begin
            // GS_PAUSE, GS_OVER and unknown encodings hold the position.
            commit_x = pos_x_q;
            commit_y = pos_y_q;
          end
        endcase
        pos_x_d       = commit_x;
        pos_y_d       = commit_y;
        moving_d      = (commit_x != pos_x_q) || (commit_y != pos_y_q);
        update_done_d = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      game_q        <= GS_IDLE;
      set_prev_q    <= 1'b0;
      speed_q       <= 2'd0;
      step_q        <= 4'd1;
      next_x_q      <= X_HOME;
      next_y_q      <= Y_HOME;
      pos_x_q       <= X_HOME;
      pos_y_q       <= Y_HOME;
      moving_q      <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q       <= state_d;
      game_q        <= game_d;
      set_prev_q    <= set_prev_d;
      speed_q       <= speed_d;
      step_q        <= step_d;
      next_x_q      <= next_x_d;
      next_y_q      <= next_y_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      moving_q      <= moving_d;
      update_done_q <= update_done_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign speed       = speed_q;
  assign moving      = moving_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Directed bench for sprite_motion_ctrl: a vector table of single-frame moves
// followed by hand-written multi-frame sequences (clamping, speed wrap,
// pause/idle, coincident speed edge, reset during an update).
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic [2:0]  stateGame = 3'd0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        setSpeed = 1'b0;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [1:0]  speed;
  logic        moving;
  logic        update_done;

  int total = 0;
  int bad   = 0;

  sprite_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .stateGame   (stateGame),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .setSpeed    (setSpeed),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .speed       (speed),
    .moving      (moving),
    .update_done (update_done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  gs;
    logic        u, d, l, r;
    logic [10:0] ex;
    logic [9:0]  ey;
    logic        em;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] gs, input logic u, input logic d,
                        input logic l, input logic r);
    stateGame = gs;
    up = u; down = d; left = l; right = r;
  endtask

  // One frame: pulse frame_tick (optionally with setSpeed raised in the same
  // cycle), expect update_done two edges later, check the committed outputs
  // and that the pulse lasts one cycle.
  task automatic do_tick(input string tag, input logic sp, input logic [10:0] ex,
                         input logic [9:0] ey, input logic em);
    int lat;
    @(negedge clk);
    frame_tick = 1'b1;
    if (sp) setSpeed = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    lat = 0;
    while (!update_done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " pos_x"}, pos_x, ex);
    check({tag, " pos_y"}, pos_y, ey);
    check({tag, " moving"}, moving, em);
    @(negedge clk);
    check({tag, " pulse_width"}, update_done, 0);
  endtask

  task automatic press_speed();
    @(negedge clk) setSpeed = 1'b1;
    repeat (2) @(negedge clk);
    setSpeed = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx;
    int nx;
    int highs;
    logic em;

    //            gs        u  d  l  r   x       y      moving
    vecs[0]  = '{GS_RUN,   0, 0, 0, 1, 11'd391, 10'd290, 1'b1};
    vecs[1]  = '{GS_RUN,   0, 0, 0, 1, 11'd392, 10'd290, 1'b1};
    vecs[2]  = '{GS_RUN,   0, 0, 0, 1, 11'd393, 10'd290, 1'b1};
    vecs[3]  = '{GS_RUN,   0, 1, 0, 0, 11'd393, 10'd291, 1'b1};
    vecs[4]  = '{GS_RUN,   1, 1, 0, 0, 11'd393, 10'd291, 1'b0};
    vecs[5]  = '{GS_RUN,   1, 0, 1, 1, 11'd393, 10'd290, 1'b1};
    vecs[6]  = '{GS_PAUSE, 1, 1, 1, 1, 11'd393, 10'd290, 1'b0};
    vecs[7]  = '{GS_IDLE,  0, 0, 0, 0, 11'd390, 10'd290, 1'b1};
    vecs[8]  = '{GS_OVER,  0, 0, 0, 1, 11'd390, 10'd290, 1'b0};
    vecs[9]  = '{3'd5,     0, 0, 0, 1, 11'd390, 10'd290, 1'b0};
    vecs[10] = '{GS_RUN,   1, 0, 1, 0, 11'd389, 10'd289, 1'b1};
    vecs[11] = '{GS_IDLE,  0, 0, 0, 0, 11'd390, 10'd290, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst pos_x", pos_x, 390);
    check("rst pos_y", pos_y, 290);
    check("rst speed", speed, 0);
    check("rst moving", moving, 0);
    check("rst update_done", update_done, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle no_update", update_done, 0);

    // Single-frame vectors at speed 0
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].gs, vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r);
      do_tick($sformatf("vec%0d", i), 1'b0, vecs[i].ex, vecs[i].ey, vecs[i].em);
    end

    // Speed 0 -> 3, then left for 50 frames clamps at x = 0
    for (int i = 1; i <= 3; i++) begin
      press_speed();
      check($sformatf("speed press%0d", i), speed, i);
    end
    set_in(GS_RUN, 0, 0, 1, 0);
    mx = 390;
    for (int i = 1; i <= 50; i++) begin
      nx = mx - 8;
      if (nx < 0) nx = 0;
      em = (nx != mx);
      mx = nx;
      do_tick($sformatf("left%0d", i), 1'b0, 11'(mx), 10'd290, em);
    end
    check("left final x", pos_x, 0);
    press_speed();
    check("speed wrap", speed, 0);

    // Back to step 8: up+down cancel, right saturates at 780
    repeat (3) press_speed();
    check("speed back to 3", speed, 3);
    set_in(GS_RUN, 1, 1, 0, 1);
    for (int i = 1; i <= 100; i++) begin
      nx = mx + 8;
      if (nx > 780) nx = 780;
      em = (nx != mx);
      mx = nx;
      do_tick($sformatf("right%0d", i), 1'b0, 11'(mx), 10'd290, em);
    end
    check("right final x", pos_x, 780);

    // Pause holds with all buttons, idle returns home
    set_in(GS_PAUSE, 1, 1, 1, 1);
    do_tick("pause", 1'b0, 11'd780, 10'd290, 1'b0);
    set_in(GS_IDLE, 1, 1, 1, 1);
    do_tick("home", 1'b0, 11'd390, 10'd290, 1'b1);

    // setSpeed edge in the tick cycle: this frame step 8, next frame step 1
    set_in(GS_RUN, 0, 0, 0, 1);
    do_tick("coinc old_step", 1'b1, 11'd398, 10'd290, 1'b1);
    setSpeed = 1'b0;
    check("coinc speed", speed, 0);
    do_tick("coinc new_step", 1'b0, 11'd399, 10'd290, 1'b1);

    // Reset asserted while the commit is pending
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1;
    check("midrst pos_x", pos_x, 390);
    check("midrst pos_y", pos_y, 290);
    check("midrst speed", speed, 0);
    check("midrst moving", moving, 0);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      if (update_done) highs++;
    end
    check("midrst no_pulse", highs, 0);
    check("midrst hold_x", pos_x, 390);
    do_tick("after_rst", 1'b0, 11'd391, 10'd290, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
